// File: rtl/node_arbiter.sv
// Round-robin arbiter that time-shares one neuron compute node among NREQ requesters:
// latches the winner's operands, waits NODE_LAT cycles, then returns the node result.
module node_arbiter #(
   parameter int NREQ     = 4,
   parameter int W        = 4,
   parameter int NODE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_in1,
   input  logic [NREQ*W-1:0] req_in2,
   input  logic [NREQ*W-1:0] req_in3,
   input  logic [NREQ*W-1:0] req_in4,
   output logic [W-1:0]      node_in1,
   output logic [W-1:0]      node_in2,
   output logic [W-1:0]      node_in3,
   output logic [W-1:0]      node_in4,
   input  logic [W-1:0]      node_out,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   resp_valid,
   output logic [W-1:0]      resp_out,
   output logic              proc,
   output logic              rdy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(NODE_LAT + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(NODE_LAT - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] owner_q, owner_d;
   logic [W-1:0]    node_in1_d, node_in2_d, node_in3_d, node_in4_d;
   logic [W-1:0]    resp_out_d;
   logic [NREQ-1:0] grant_d, resp_valid_d;
   logic            proc_d, rdy_d;
   logic            found;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_onehot;

   // Requester index at a given distance from the pointer; NREQ need not be a power of 2.
   function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NREQ) sum = sum - NREQ;
      return PW'(sum);
   endfunction

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[rr_index(ptr_q, k)]) begin
            found   = 1'b1;
            win_idx = rr_index(ptr_q, k);
         end
      end
   end

   assign win_onehot = NREQ'(1) << win_idx;

   // Requests are only considered in IDLE; RUN just counts down the node latency.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      node_in1_d   = node_in1;
      node_in2_d   = node_in2;
      node_in3_d   = node_in3;
      node_in4_d   = node_in4;
      resp_out_d   = resp_out;
      grant_d      = '0;
      resp_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               node_in1_d = req_in1[int'(win_idx)*W +: W];
               node_in2_d = req_in2[int'(win_idx)*W +: W];
               node_in3_d = req_in3[int'(win_idx)*W +: W];
               node_in4_d = req_in4[int'(win_idx)*W +: W];
               grant_d    = win_onehot;
               owner_d    = win_onehot;
               ptr_d      = (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
               cnt_d      = CNT_INIT;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               resp_out_d   = node_out;
               resp_valid_d = owner_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      proc_d = (state_d == RUN);
      rdy_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         owner_q    <= '0;
         node_in1   <= '0;
         node_in2   <= '0;
         node_in3   <= '0;
         node_in4   <= '0;
         resp_out   <= '0;
         grant      <= '0;
         resp_valid <= '0;
         proc       <= 1'b0;
         rdy        <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         node_in1   <= node_in1_d;
         node_in2   <= node_in2_d;
         node_in3   <= node_in3_d;
         node_in4   <= node_in4_d;
         resp_out   <= resp_out_d;
         grant      <= grant_d;
         resp_valid <= resp_valid_d;
         proc       <= proc_d;
         rdy        <= rdy_d;
      end
   end

endmodule

// File: tb/tb_node_arbiter.sv
// Directed bench for node_arbiter: default 4-requester instance plus two NREQ=3
// instances (NODE_LAT=4 and NODE_LAT=1) exercised with the same reset.
module tb_node_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_in1, req_in2, req_in3, req_in4;
   logic [3:0]  node_in1, node_in2, node_in3, node_in4, node_out;
   logic [3:0]  grant, resp_valid, resp_out;
   logic        proc, rdy;

   logic [2:0]  sw_req;
   logic [11:0] sw_in1, sw_in2, sw_in3, sw_in4;
   logic [3:0]  b_node_in1, b_node_in2, b_node_in3, b_node_in4, b_node_out, b_resp_out;
   logic [2:0]  b_grant, b_resp_valid;
   logic        b_proc, b_rdy;
   logic [3:0]  c_node_in1, c_node_in2, c_node_in3, c_node_in4, c_node_out, c_resp_out;
   logic [2:0]  c_grant, c_resp_valid;
   logic        c_proc, c_rdy;

   int compared;
   int mismatched;
   int exp_g, exp_v;

   // Node model: result is operand1 + operand3 (mod 16).
   assign node_out   = node_in1 + node_in3;
   assign b_node_out = b_node_in1 + b_node_in3;
   assign c_node_out = c_node_in1 + c_node_in3;

   node_arbiter #(.NREQ(4), .W(4), .NODE_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3), .req_in4(req_in4),
      .node_in1(node_in1), .node_in2(node_in2), .node_in3(node_in3), .node_in4(node_in4),
      .node_out(node_out), .grant(grant), .resp_valid(resp_valid), .resp_out(resp_out),
      .proc(proc), .rdy(rdy)
   );

   node_arbiter #(.NREQ(3), .W(4), .NODE_LAT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(sw_req),
      .req_in1(sw_in1), .req_in2(sw_in2), .req_in3(sw_in3), .req_in4(sw_in4),
      .node_in1(b_node_in1), .node_in2(b_node_in2), .node_in3(b_node_in3), .node_in4(b_node_in4),
      .node_out(b_node_out), .grant(b_grant), .resp_valid(b_resp_valid), .resp_out(b_resp_out),
      .proc(b_proc), .rdy(b_rdy)
   );

   node_arbiter #(.NREQ(3), .W(4), .NODE_LAT(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .req(sw_req),
      .req_in1(sw_in1), .req_in2(sw_in2), .req_in3(sw_in3), .req_in4(sw_in4),
      .node_in1(c_node_in1), .node_in2(c_node_in2), .node_in3(c_node_in3), .node_in4(c_node_in4),
      .node_out(c_node_out), .grant(c_grant), .resp_valid(c_resp_valid), .resp_out(c_resp_out),
      .proc(c_proc), .rdy(c_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_operands(input int idx, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
      req_in1[idx*4 +: 4] = a;
      req_in2[idx*4 +: 4] = b;
      req_in3[idx*4 +: 4] = c;
      req_in4[idx*4 +: 4] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req    = '0;
      sw_req = '0;
      rst_n  = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      req        = '0;
      req_in1    = '0;
      req_in2    = '0;
      req_in3    = '0;
      req_in4    = '0;
      sw_req     = '0;
      sw_in1     = '0;
      sw_in2     = '0;
      sw_in3     = '0;
      sw_in4     = '0;

      // reset state
      next_cycle();
      next_cycle();
      check_output("rst_grant", grant, 0);
      check_output("rst_resp_valid", resp_valid, 0);
      check_output("rst_proc", proc, 0);
      check_output("rst_rdy", rdy, 0);
      check_output("rst_node_in1", node_in1, 0);
      check_output("rst_resp_out", resp_out, 0);
      check_output("rst_b_rdy", b_rdy, 0);
      rst_n = 1'b1;
      next_cycle();
      check_output("rdy_after_rst", rdy, 1);
      check_output("proc_after_rst", proc, 0);

      // single requester
      set_operands(0, 4'd3, 4'd5, 4'd7, 4'd9);
      req = 4'b0001;
      next_cycle();
      check_output("t1_grant", grant, 4'b0001);
      check_output("t1_proc", proc, 1);
      check_output("t1_rdy", rdy, 0);
      check_output("t1_node_in1", node_in1, 3);
      check_output("t1_node_in2", node_in2, 5);
      check_output("t1_node_in3", node_in3, 7);
      check_output("t1_node_in4", node_in4, 9);
      req = 4'b0000;
      next_cycle();
      check_output("t1_grant_pulse", grant, 0);
      check_output("t1_proc_run2", proc, 1);
      check_output("t1_no_early_resp", resp_valid, 0);
      next_cycle();
      check_output("t1_resp_valid", resp_valid, 4'b0001);
      check_output("t1_resp_out", resp_out, 4'hA);
      check_output("t1_proc_done", proc, 0);
      check_output("t1_rdy_done", rdy, 1);
      next_cycle();
      check_output("t1_resp_pulse", resp_valid, 0);
      check_output("t1_resp_hold", resp_out, 4'hA);

      // all four requesting: round robin, one transaction every 3 cycles
      do_reset();
      for (int i = 0; i < 4; i++) set_operands(i, 4'(i), 4'd1, 4'(4 + i), 4'd2);
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         next_cycle();
         check_output("t2_grant", grant, 32'(1 << (t % 4)));
         check_output("t2_node_in1", node_in1, 32'(t % 4));
         if (t == 4) req = 4'b0000;
         next_cycle();
         check_output("t2_grant_gap", grant, 0);
         next_cycle();
         check_output("t2_resp_valid", resp_valid, 32'(1 << (t % 4)));
         check_output("t2_resp_out", resp_out, 32'(4 + 2 * (t % 4)));
      end

      // pointer order: after 0100, requester 3 precedes requester 0
      do_reset();
      set_operands(2, 4'd1, 4'd0, 4'd1, 4'd0);
      set_operands(3, 4'd3, 4'd0, 4'd3, 4'd0);
      set_operands(0, 4'd5, 4'd0, 4'd5, 4'd0);
      req = 4'b0100;
      next_cycle();
      check_output("t3_grant_2", grant, 4'b0100);
      req = 4'b0000;
      next_cycle();
      next_cycle();
      check_output("t3_resp_2", resp_valid, 4'b0100);
      check_output("t3_out_2", resp_out, 2);
      req = 4'b1001;
      next_cycle();
      check_output("t3_grant_3", grant, 4'b1000);
      check_output("t3_node_in1_3", node_in1, 3);
      req = 4'b0001;
      next_cycle();
      next_cycle();
      check_output("t3_resp_3", resp_valid, 4'b1000);
      check_output("t3_out_3", resp_out, 6);
      next_cycle();
      check_output("t3_grant_0", grant, 4'b0001);
      req = 4'b0000;
      next_cycle();
      next_cycle();
      check_output("t3_resp_0", resp_valid, 4'b0001);
      check_output("t3_out_0", resp_out, 4'hA);

      // request raised and dropped during RUN is never granted
      set_operands(1, 4'd1, 4'd1, 4'd5, 4'd2);
      req = 4'b0010;
      next_cycle();
      check_output("t6_grant_1", grant, 4'b0010);
      req = 4'b0100;
      next_cycle();
      check_output("t6_ignored_run", grant, 0);
      req = 4'b0000;
      next_cycle();
      check_output("t6_resp_1", resp_valid, 4'b0010);
      check_output("t6_no_grant_a", grant, 0);
      next_cycle();
      check_output("t6_no_grant_b", grant, 0);
      check_output("t6_idle_proc", proc, 0);
      next_cycle();
      check_output("t6_no_grant_c", grant, 0);
      check_output("t6_idle_rdy", rdy, 1);

      // reset during the second RUN cycle aborts the transaction
      req = 4'b0010;
      next_cycle();
      check_output("t4_grant", grant, 4'b0010);
      req = 4'b0000;
      next_cycle();
      check_output("t4_proc_run2", proc, 1);
      rst_n = 1'b0;
      next_cycle();
      check_output("t4_rst_resp_valid", resp_valid, 0);
      check_output("t4_rst_grant", grant, 0);
      check_output("t4_rst_proc", proc, 0);
      check_output("t4_rst_rdy", rdy, 0);
      check_output("t4_rst_node_in1", node_in1, 0);
      check_output("t4_rst_resp_out", resp_out, 0);
      rst_n = 1'b1;
      next_cycle();
      check_output("t4_no_late_resp", resp_valid, 0);
      check_output("t4_rdy", rdy, 1);
      req = 4'b1010;
      next_cycle();
      check_output("t4_ptr_zero_grant", grant, 4'b0010);
      req = 4'b0000;
      next_cycle();
      next_cycle();
      check_output("t4_resp", resp_valid, 4'b0010);
      check_output("t4_resp_out", resp_out, 6);

      // NREQ=3 sweep: NODE_LAT=4 (dut_b) and NODE_LAT=1 (dut_c), pointer wraps 2 -> 0
      do_reset();
      sw_in1 = {4'd3, 4'd2, 4'd1};
      sw_in3 = {4'd2, 4'd2, 4'd2};
      sw_req = 3'b111;
      for (int c = 1; c <= 16; c++) begin
         next_cycle();
         exp_g = ((c - 1) % 2 == 0) ? (1 << (((c - 1) / 2) % 3)) : 0;
         exp_v = ((c - 1) % 2 == 1) ? (1 << (((c - 2) / 2) % 3)) : 0;
         check_output("sw_lat1_grant", c_grant, 32'(exp_g));
         check_output("sw_lat1_resp_valid", c_resp_valid, 32'(exp_v));
         if (exp_v != 0) check_output("sw_lat1_resp_out", c_resp_out, 32'(((c - 2) / 2) % 3 + 3));
         exp_g = ((c - 1) % 5 == 0) ? (1 << (((c - 1) / 5) % 3)) : 0;
         exp_v = ((c - 1) % 5 == 4) ? (1 << (((c - 5) / 5) % 3)) : 0;
         check_output("sw_lat4_grant", b_grant, 32'(exp_g));
         check_output("sw_lat4_resp_valid", b_resp_valid, 32'(exp_v));
         if (exp_v != 0) check_output("sw_lat4_resp_out", b_resp_out, 32'(((c - 5) / 5) % 3 + 3));
      end
      sw_req = 3'b000;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/node_arbiter.md
# node_arbiter

Round-robin arbiter and sequencer that time-shares one neuron compute node (the `lif` datapath wrapped by `block`) among NREQ requesters. It latches the winning requester's four W-bit operands onto the node inputs and holds them for NODE_LAT cycles. It then captures the node output and returns it to that requester with a one-cycle valid pulse. It replaces per-requester node instances where area matters, and drives the same proc/rdy phase indicators the fabric already uses.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand/result width
- NODE_LAT, 2, cycles from node inputs stable to node_out valid (≥1)

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset rst_n, synchronous, active-low; clock clk
- req  in  NREQ  level request per requester
- req_in1..req_in4  in  NREQ*W each  operands; requester i at bits [i*W +: W]
- node_in1..node_in4  out  W each  registered operands to the shared node
- node_out  in  W  shared node result
- grant  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured
- resp_valid  out  NREQ  one-hot, one-cycle pulse: resp_out belongs to that requester
- resp_out  out  W  captured node result
- proc  out  1  high while a transaction occupies the node
- rdy  out  1  high while idle and able to accept a request

## Operation
- States: IDLE, RUN. Registers: state, ptr (round-robin pointer, $clog2(NREQ) bits), cnt ($clog2(NODE_LAT+1) bits), owner (one-hot), node_in1..4, resp_out.
- IDLE, any req set: winner = first set req bit scanning ptr, ptr+1, … mod NREQ. On the edge: node_inX <= winner's req_inX; grant <= onehot(winner); owner <= onehot(winner); ptr <= (winner+1) mod NREQ; cnt <= NODE_LAT-1; state <= RUN.
- IDLE, no req: all outputs hold except grant/resp_valid, which are 0.
- RUN, cnt≠0: cnt decrements. RUN, cnt==0: resp_out <= node_out; resp_valid <= owner; state <= IDLE.
- Requests are ignored during RUN, with no queuing beyond the level of req. The requester holds req and operands until it sees grant, then deasserts req. A req still high in IDLE after resp_valid counts as a new request.
- node_in1..4 stay stable from grant until the next grant. resp_out holds until the next capture.
- proc = (state==RUN). rdy = (state==IDLE), registered with state.
- Width rules: no arithmetic on data; ptr wraps modulo NREQ (explicit compare when NREQ is not a power of 2).

## Timing
- Reset (rst_n low at an edge): state IDLE, ptr 0, cnt 0, owner 0, node_in1..4 0, resp_out 0, grant 0, resp_valid 0, proc 0, rdy 0. rdy rises the first cycle after rst_n is sampled high.
- With req sampled at edge E: grant and proc are high in cycle E+1. resp_valid is high in cycle E+1+NODE_LAT, with proc low and rdy high in that same cycle.
- The node samples node_in for NODE_LAT full cycles. node_out is sampled at the edge ending the NODE_LAT-th RUN cycle.
- Back-to-back: a req visible during the resp_valid cycle is granted the next cycle. Transaction period is NODE_LAT+1 cycles.
- Simultaneous requests: exactly one grant per transaction, in pointer order. No requester waits more than NREQ-1 transactions.
- NODE_LAT=1: grant in cycle E+1, resp_valid in cycle E+2.
- Reset mid-RUN aborts the transaction: no resp_valid is issued, ptr returns to 0, and the interrupted requester must re-request.
- grant and resp_valid never exceed one bit set and are never both set for the same requester in the same cycle.

## Test plan
- Reset, then single requester: req=0001, req_in1..4=3,5,7,9 at cycle 0 → grant=0001 cycle 1, node_in=3,5,7,9, proc=1 cycles 1–2; node model returns 0xA → resp_valid=0001, resp_out=0xA in cycle 3, rdy=1.
- All four req held high, operands distinct → grants in order 0001,0010,0100,1000,0001, one every 3 cycles; each resp_out matches its owner's operands via the node model.
- req=0100 only, then req=1001 → after 0100, ptr=3, so 1000 is granted before 0001.
- rst_n low during cycle 2 of RUN → no resp_valid; all outputs 0; ptr=0. After release, req=0010 is granted normally.
- Parameter sweep NODE_LAT=1 and NODE_LAT=4, NREQ=3 → resp_valid exactly NODE_LAT cycles after grant; ptr wraps 2→0.
- req asserted during RUN and dropped before IDLE → never granted; grant remains 0.
